// File: rtl/iter_alu.sv
// Iterative integer ALU: base ops complete in one registered cycle, M-extension
// multiply/divide iterate one bit per cycle behind a valid/ready handshake.
module iter_alu #(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero
);

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    localparam logic [WIDTH-1:0]        ONE  = WIDTH'(1);
    localparam logic [SHW-1:0]          LAST = SHW'(WIDTH - 1);
    localparam logic signed [WIDTH-1:0] SMIN = {1'b1, {(WIDTH-1){1'b0}}};

    function automatic logic [WIDTH-1:0] negate(input logic [WIDTH-1:0] x);
        return ~x + ONE;
    endfunction

    function automatic logic [WIDTH-1:0] magnitude(input logic signed [WIDTH-1:0] x,
                                                   input logic is_signed);
        return (is_signed && x[WIDTH-1]) ? negate(x) : x;
    endfunction

    function automatic logic [WIDTH-1:0] base_op(input logic [WIDTH-1:0] x,
                                                 input logic [WIDTH-1:0] y,
                                                 input logic [3:0]       opc);
        logic [WIDTH:0]   diff;
        logic             ovf;
        logic             lt;
        logic [SHW-1:0]   sh;
        logic [WIDTH-1:0] r;
        // diff carries out 1 exactly when x >= y unsigned; signed lt needs overflow correction
        diff = {1'b0, x} + {1'b0, ~y} + {{WIDTH{1'b0}}, 1'b1};
        ovf  = (x[WIDTH-1] ^ y[WIDTH-1]) & (diff[WIDTH-1] ^ x[WIDTH-1]);
        lt   = diff[WIDTH-1] ^ ovf;
        sh   = y[SHW-1:0];
        case (opc)
            4'd0:    r = x + y;
            4'd1:    r = diff[WIDTH-1:0];
            4'd2:    r = x & y;
            4'd3:    r = x | y;
            4'd4:    r = x ^ y;
            4'd5:    r = {{(WIDTH-1){1'b0}}, lt};
            4'd6:    r = x << sh;
            4'd7:    r = x >> sh;
            4'd8:    r = $unsigned($signed(x) >>> sh);
            4'd9:    r = {{(WIDTH-1){1'b0}}, ~diff[WIDTH]};
            default: r = '0;
        endcase
        return r;
    endfunction

    function automatic logic [WIDTH-1:0] fix_result(input logic [3:0]              opc,
                                                    input logic signed [WIDTH-1:0] xs,
                                                    input logic signed [WIDTH-1:0] ys,
                                                    input logic [WIDTH-1:0]        lo,
                                                    input logic [WIDTH-1:0]        hi);
        logic sgn;
        logic want_rem;
        sgn      = ~opc[0];
        want_rem = opc[1];
        if (opc[3:1] == 3'b101)
            return opc[0] ? hi : lo;
        if (ys == '0)
            return want_rem ? xs : '1;
        if (sgn && xs == SMIN && ys == '1)
            return want_rem ? '0 : xs;
        if (want_rem)
            return (sgn && xs[WIDTH-1]) ? negate(hi) : hi;
        return (sgn && (xs[WIDTH-1] ^ ys[WIDTH-1])) ? negate(lo) : lo;
    endfunction

    state_t                   state;
    logic [SHW-1:0]           cnt;
    logic [3:0]               op_p0;
    logic signed [WIDTH-1:0]  a_p0;
    logic signed [WIDTH-1:0]  b_p0;
    logic [WIDTH-1:0]         hi_p1;
    logic [WIDTH-1:0]         lo_p1;
    logic [WIDTH-1:0]         m_p1;
    logic                     vld_p2;

    logic                     accept;
    logic                     in_multi;
    logic                     in_mul;
    logic                     is_mul;
    logic [WIDTH-1:0]         base_res;
    logic [WIDTH-1:0]         fix_res;
    logic [WIDTH-1:0]         lo_ld;
    logic [WIDTH-1:0]         m_ld;
    logic [WIDTH:0]           mstep;
    logic [WIDTH:0]           dshift;
    logic [WIDTH:0]           ddiff;
    logic                     qbit;
    logic [WIDTH-1:0]         hi_nx;
    logic [WIDTH-1:0]         lo_nx;

    assign in_ready  = (state == IDLE) | ((state == DONE) & out_ready);
    assign accept    = in_valid & in_ready & ~flush;
    assign out_valid = vld_p2;
    assign in_multi  = op[3] & (op[2] | op[1]);
    assign in_mul    = (op[3:1] == 3'b101);
    assign is_mul    = (op_p0[3:1] == 3'b101);
    assign base_res  = base_op(a, b, op);
    assign fix_res   = fix_result(op_p0, a_p0, b_p0, lo_p1, hi_p1);

    // Multiply works on raw unsigned operands; divide works on magnitudes
    assign lo_ld = in_mul ? b : magnitude(a, ~op[0]);
    assign m_ld  = in_mul ? a : magnitude(b, ~op[0]);

    always_comb begin
        mstep  = {1'b0, hi_p1} + (lo_p1[0] ? {1'b0, m_p1} : {(WIDTH+1){1'b0}});
        dshift = {hi_p1, lo_p1[WIDTH-1]};
        ddiff  = dshift - {1'b0, m_p1};
        qbit   = ~ddiff[WIDTH];
        hi_nx  = hi_p1;
        lo_nx  = lo_p1;
        if (is_mul) begin
            hi_nx = mstep[WIDTH:1];
            lo_nx = {mstep[0], lo_p1[WIDTH-1:1]};
        end else begin
            hi_nx = qbit ? ddiff[WIDTH-1:0] : dshift[WIDTH-1:0];
            lo_nx = {lo_p1[WIDTH-2:0], qbit};
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state  <= IDLE;
            cnt    <= '0;
            op_p0  <= '0;
            a_p0   <= '0;
            b_p0   <= '0;
            hi_p1  <= '0;
            lo_p1  <= '0;
            m_p1   <= '0;
            vld_p2 <= 1'b0;
            result <= '0;
            zero   <= 1'b1;
        end else if (flush) begin
            state  <= IDLE;
            vld_p2 <= 1'b0;
        end else begin
            case (state)
                // ---- stage 0: accept / single-cycle ops ----
                IDLE, DONE: begin
                    if (accept) begin
                        op_p0 <= op;
                        a_p0  <= a;
                        b_p0  <= b;
                        if (in_multi) begin
                            state  <= CALC;
                            cnt    <= '0;
                            vld_p2 <= 1'b0;
                            hi_p1  <= '0;
                            lo_p1  <= lo_ld;
                            m_p1   <= m_ld;
                        end else begin
                            state  <= DONE;
                            vld_p2 <= 1'b1;
                            result <= base_res;
                            zero   <= (base_res == '0);
                        end
                    end else if (state == DONE && out_ready) begin
                        state  <= IDLE;
                        vld_p2 <= 1'b0;
                    end
                end
                // ---- stage 1: one multiply/divide bit per cycle ----
                CALC: begin
                    hi_p1 <= hi_nx;
                    lo_p1 <= lo_nx;
                    cnt   <= cnt + SHW'(1);
                    if (cnt == LAST)
                        state <= FIX;
                end
                // ---- stage 2: sign fix-up and special cases ----
                FIX: begin
                    result <= fix_res;
                    zero   <= (fix_res == '0);
                    vld_p2 <= 1'b1;
                    state  <= DONE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_iter_alu.sv
// Bench for iter_alu: directed vectors, randomized ops against an arithmetic
// reference model, and handshake / flush / reset sequences.
module tb_iter_alu;

    localparam int W = 32;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          flush = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [W-1:0]  a = '0;
    logic [W-1:0]  b = '0;
    logic [3:0]    op = '0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [W-1:0]  result;
    logic          zero;

    int n_checks = 0;
    int n_fail   = 0;

    iter_alu #(.WIDTH(W)) dut (
        .clk(clk),
        .reset_n(reset_n),
        .flush(flush),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .a(a),
        .b(b),
        .op(op),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .result(result),
        .zero(zero)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] res;
        logic         zr;
        int           lat;
    } vec_t;

    vec_t vecs[$];

    task automatic addv(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                        input logic [W-1:0] r, input logic z, input int l);
        vec_t v;
        v.op = o; v.a = x; v.b = y; v.res = r; v.zr = z; v.lat = l;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Reference model: plain arithmetic on the instruction semantics
    function automatic logic [W-1:0] model(input logic [3:0] o, input logic [W-1:0] x,
                                           input logic [W-1:0] y);
        logic [63:0]         p;
        logic signed [W-1:0] sx;
        logic signed [W-1:0] sy;
        logic                ovf;
        sx  = x;
        sy  = y;
        p   = {32'b0, x} * {32'b0, y};
        ovf = (x == 32'h8000_0000) && (y == 32'hFFFF_FFFF);
        case (o)
            4'd0:  return x + y;
            4'd1:  return x - y;
            4'd2:  return x & y;
            4'd3:  return x | y;
            4'd4:  return x ^ y;
            4'd5:  return {31'b0, sx < sy};
            4'd6:  return x << y[4:0];
            4'd7:  return x >> y[4:0];
            4'd8:  return $unsigned(sx >>> y[4:0]);
            4'd9:  return {31'b0, x < y};
            4'd10: return p[31:0];
            4'd11: return p[63:32];
            4'd12: return (y == 0) ? 32'hFFFF_FFFF : ovf ? x : $unsigned(sx / sy);
            4'd13: return (y == 0) ? 32'hFFFF_FFFF : x / y;
            4'd14: return (y == 0) ? x : ovf ? 32'h0 : $unsigned(sx % sy);
            default: return (y == 0) ? x : x % y;
        endcase
    endfunction

    function automatic logic [W-1:0] pick();
        case ($urandom_range(7))
            0: return 32'h0;
            1: return 32'h8000_0000;
            2: return 32'hFFFF_FFFF;
            3: return $urandom_range(16);
            default: return $urandom;
        endcase
    endfunction

    task automatic run_op(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                          output logic [W-1:0] res, output logic zr, output int lat);
        int guard;
        @(negedge clk);
        op = o; a = x; b = y; in_valid = 1'b1; out_ready = 1'b1;
        guard = 0;
        while (!in_ready && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a = $urandom;
        b = $urandom;
        lat = 1;
        while (!out_valid && lat < 200) begin
            @(posedge clk);
            #1;
            lat++;
        end
        res = result;
        zr  = zero;
    endtask

    task automatic settle();
        out_ready = 1'b1;
        in_valid  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        logic [W-1:0] res;
        logic [W-1:0] exp;
        logic         zr;
        int           lat;
        int           seen;
        int           guard;

        addv(4'd0,  32'h7FFF_FFFF, 32'd1,         32'h8000_0000, 1'b0, 1);
        addv(4'd0,  32'hFFFF_FFFF, 32'd1,         32'h0,         1'b1, 1);
        addv(4'd1,  32'd5,         32'd5,         32'h0,         1'b1, 1);
        addv(4'd5,  32'hFFFF_FFFF, 32'd1,         32'd1,         1'b0, 1);
        addv(4'd9,  32'hFFFF_FFFF, 32'd1,         32'd0,         1'b1, 1);
        addv(4'd8,  32'h8000_0000, 32'd4,         32'hF800_0000, 1'b0, 1);
        addv(4'd7,  32'h8000_0000, 32'h1F,        32'd1,         1'b0, 1);
        addv(4'd6,  32'd1,         32'h21,        32'd2,         1'b0, 1);
        addv(4'd2,  32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 1'b0, 1);
        addv(4'd3,  32'hF0F0_F0F0, 32'h0F0F_0F0F, 32'hFFFF_FFFF, 1'b0, 1);
        addv(4'd4,  32'hAAAA_AAAA, 32'hAAAA_AAAA, 32'h0,         1'b1, 1);
        addv(4'd10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h1,         1'b0, 34);
        addv(4'd11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0, 34);
        addv(4'd12, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 1'b0, 34);
        addv(4'd14, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 1'b0, 34);
        addv(4'd13, 32'd100,       32'd7,         32'd14,        1'b0, 34);
        addv(4'd15, 32'd100,       32'd7,         32'd2,         1'b0, 34);
        addv(4'd12, 32'd5,         32'd0,         32'hFFFF_FFFF, 1'b0, 34);
        addv(4'd14, 32'd5,         32'd0,         32'd5,         1'b0, 34);
        addv(4'd12, 32'hFFFF_FFF8, 32'd0,         32'hFFFF_FFFF, 1'b0, 34);
        addv(4'd14, 32'hFFFF_FFF8, 32'd0,         32'hFFFF_FFF8, 1'b0, 34);
        addv(4'd13, 32'd5,         32'd0,         32'hFFFF_FFFF, 1'b0, 34);
        addv(4'd15, 32'd5,         32'd0,         32'd5,         1'b0, 34);
        addv(4'd12, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0, 34);
        addv(4'd14, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         1'b1, 34);

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("reset out_valid", {31'b0, out_valid}, 32'd0);
        check("reset result", result, 32'd0);
        check("reset zero", {31'b0, zero}, 32'd1);
        check("reset in_ready", {31'b0, in_ready}, 32'd1);
        @(negedge clk);
        reset_n = 1'b1;

        foreach (vecs[i]) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, res, zr, lat);
            check($sformatf("vec%0d op%0d result", i, vecs[i].op), res, vecs[i].res);
            check($sformatf("vec%0d op%0d zero", i, vecs[i].op), {31'b0, zr}, {31'b0, vecs[i].zr});
            check($sformatf("vec%0d op%0d latency", i, vecs[i].op), lat, vecs[i].lat);
        end

        for (int i = 0; i < 300; i++) begin
            logic [3:0]   o;
            logic [W-1:0] x;
            logic [W-1:0] y;
            o   = 4'($urandom_range(15));
            x   = pick();
            y   = pick();
            exp = model(o, x, y);
            run_op(o, x, y, res, zr, lat);
            check($sformatf("rand%0d op%0d a=%h b=%h result", i, o, x, y), res, exp);
            check($sformatf("rand%0d zero", i), {31'b0, zr}, {31'b0, exp == 0});
            check($sformatf("rand%0d latency", i), lat, (o >= 4'd10) ? W + 2 : 1);
        end

        // Held result with stalled consumer, then back-to-back accept
        settle();
        @(negedge clk);
        op = 4'd10; a = 32'h1234_5678; b = 32'h10; in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        guard = 1;
        while (!out_valid && guard < 200) begin
            @(posedge clk);
            #1;
            guard++;
        end
        check("stall mul latency", guard, W + 2);
        for (int k = 0; k < 5; k++) begin
            check($sformatf("stall%0d out_valid", k), {31'b0, out_valid}, 32'd1);
            check($sformatf("stall%0d result", k), result, 32'h2345_6780);
            check($sformatf("stall%0d in_ready", k), {31'b0, in_ready}, 32'd0);
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        out_ready = 1'b1; in_valid = 1'b1; op = 4'd0; a = 32'd3; b = 32'd4;
        #1;
        check("b2b in_ready", {31'b0, in_ready}, 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("b2b out_valid", {31'b0, out_valid}, 32'd1);
        check("b2b result", result, 32'd7);
        check("b2b zero", {31'b0, zero}, 32'd0);

        // Flush mid-CALC with a same-cycle in_valid
        settle();
        @(negedge clk);
        op = 4'd13; a = 32'd1000; b = 32'd7; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        flush = 1'b1; in_valid = 1'b1; op = 4'd0; a = 32'd1; b = 32'd1;
        @(posedge clk);
        #1;
        flush = 1'b0; in_valid = 1'b0;
        check("flush in_ready", {31'b0, in_ready}, 32'd1);
        check("flush out_valid", {31'b0, out_valid}, 32'd0);
        seen = 0;
        repeat (50) begin
            @(posedge clk);
            #1;
            if (out_valid) seen++;
        end
        check("flush no out_valid", seen, 0);

        // Flush while idle ignores the same-cycle request
        @(negedge clk);
        flush = 1'b1; in_valid = 1'b1; op = 4'd0; a = 32'd2; b = 32'd2;
        @(posedge clk);
        #1;
        flush = 1'b0; in_valid = 1'b0;
        check("idle flush out_valid", {31'b0, out_valid}, 32'd0);
        @(posedge clk);
        #1;
        check("idle flush out_valid+1", {31'b0, out_valid}, 32'd0);

        // Flush drops a held result
        @(negedge clk);
        op = 4'd0; a = 32'd1; b = 32'd1; in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("held out_valid", {31'b0, out_valid}, 32'd1);
        check("held result", result, 32'd2);
        @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        check("held flush out_valid", {31'b0, out_valid}, 32'd0);
        check("held flush in_ready", {31'b0, in_ready}, 32'd1);
        out_ready = 1'b1;

        // Asynchronous reset mid-CALC
        settle();
        @(negedge clk);
        op = 4'd13; a = 32'd1000; b = 32'd7; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        check("async rst out_valid", {31'b0, out_valid}, 32'd0);
        check("async rst result", result, 32'd0);
        check("async rst zero", {31'b0, zero}, 32'd1);
        check("async rst in_ready", {31'b0, in_ready}, 32'd1);
        @(negedge clk);
        reset_n = 1'b1;
        seen = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (out_valid) seen++;
        end
        check("post rst no out_valid", seen, 0);
        check("post rst in_ready", {31'b0, in_ready}, 32'd1);
        run_op(4'd0, 32'd6, 32'd9, res, zr, lat);
        check("post rst add result", res, 32'd15);
        check("post rst add latency", lat, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
